// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file writeback definitions: widths, requester indices and defaults.
package rf_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 16;
    localparam int REG_AW = 4;
    localparam int NREQ   = 3;
    localparam int CNT_W  = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;
endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant with a pointer that advances past the winner on every transfer.
module rr_arbiter #(
    parameter int NREQ = rf_pkg::NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant
);
    import rf_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] win_next;
    logic [PW:0]   slot;
    logic [PW:0]   win_inc;
    logic          found;

    // Search upward from the pointer with wrap-around; first valid requester wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        slot  = '0;
        if (!rst && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                slot = {1'b0, ptr} + (PW+1)'(k);
                if (slot >= (PW+1)'(NREQ)) begin
                    slot = slot - (PW+1)'(NREQ);
                end
                if (!found && req_valid[slot[PW-1:0]]) begin
                    grant[slot[PW-1:0]] = 1'b1;
                    win                 = slot[PW-1:0];
                    found               = 1'b1;
                end
            end
        end
    end

    assign win_inc  = {1'b0, win} + (PW+1)'(1);
    assign win_next = (win_inc == (PW+1)'(NREQ)) ? '0 : win_inc[PW-1:0];

    // A grant is only ever issued to a valid requester, so found means a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= win_next;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant, registered write stage, pending mask.
// Optional conflict statistics counter enabled by defining RF_WB_ARBITER_STATS_EN.
module rf_wb_arbiter #(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int NREQ = rf_pkg::NREQ,
    parameter int NREG = rf_pkg::NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*4-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_wd,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [3:0]           rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    output logic [NREG-1:0]      pend_mask,
    output logic [15:0]          conflict_cnt
);
    import rf_pkg::*;

    logic [NREQ-1:0]   grant;
    logic              xfer;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_wd;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // One-hot grant selects the winning destination and data.
    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd = req_rd[REG_AW*i +: REG_AW];
                sel_wd = req_wd[XLEN*i +: XLEN];
            end
        end
    end

    // Output stage: writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= xfer && (sel_rd != '0);
            if (xfer) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_wd;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        if (rf_we) begin
            pend_mask[rf_rd] = 1'b1;
        end
    end

`ifdef RF_WB_ARBITER_STATS_EN
    logic [CNT_W-1:0] conflict_q;
    logic             multi;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi = |(req_valid & (req_valid - NREQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (multi && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif
endmodule
